// File: rtl/sm3_perm_pkg.sv
// Shared types and helpers for the pipelined SM3 permutation unit.
package sm3_perm_pkg;

  localparam int unsigned LANE_W     = 32;
  localparam int unsigned STAGES_MIN = 1;
  localparam int unsigned STAGES_MAX = 4;

  typedef enum logic [1:0] {
    OP_P0 = 2'd0,
    OP_P1 = 2'd1,
    OP_L  = 2'd2,
    OP_LP = 2'd3
  } op_e;

  function automatic logic [LANE_W-1:0] rol32(input logic [LANE_W-1:0] x, input int unsigned n);
    return (x << n) | (x >> (LANE_W - n));
  endfunction

endpackage

// File: rtl/sm3_perm_lane.sv
// Combinational 32-bit lane: SM3 P0/P1, plus SM4 L/L' when SM3_PERM_SM4_LINEAR_EN is defined.
module sm3_perm_lane
  import sm3_perm_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic [31:0] x_i,
  output logic [31:0] y_o
);

  always_comb begin
    y_o = '0;
    case (op_e'(op_i))
      OP_P0: y_o = x_i ^ rol32(x_i, 9) ^ rol32(x_i, 17);
      OP_P1: y_o = x_i ^ rol32(x_i, 15) ^ rol32(x_i, 23);
`ifdef SM3_PERM_SM4_LINEAR_EN
      OP_L:  y_o = x_i ^ rol32(x_i, 2) ^ rol32(x_i, 10) ^ rol32(x_i, 18) ^ rol32(x_i, 24);
      OP_LP: y_o = x_i ^ rol32(x_i, 13) ^ rol32(x_i, 23);
`endif
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/sm3_perm_pipe.sv
// Pipelined SIMD SM3 P0/P1 functional unit with valid/ready backpressure and flush.
// Optional SM4 L/L' ops enabled by defining SM3_PERM_SM4_LINEAR_EN.
module sm3_perm_pipe
  import sm3_perm_pkg::*;
#(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned STAGES        = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  input  logic [1:0]               op_i,
  input  logic                     simd_i,
  input  logic [XLEN-1:0]          operand_i,
  input  logic                     flush_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [XLEN-1:0]          result_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o,
  output logic                     busy_o
);

  localparam int unsigned LANES = XLEN / LANE_W;

  logic [XLEN-1:0]          lane_res;
  logic [STAGES-1:0]        v_q, v_d, en;
  logic [XLEN-1:0]          res_q [STAGES];
  logic [TRANS_ID_BITS-1:0] id_q  [STAGES];
  logic                     accept;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [LANE_W-1:0] y;
    sm3_perm_lane u_lane (
      .op_i (op_i),
      .x_i  (operand_i[g*LANE_W +: LANE_W]),
      .y_o  (y)
    );
    // Upper lanes only contribute in SIMD mode; lane 0 always does.
    if (g == 0) begin : g_lo
      assign lane_res[LANE_W-1:0] = y;
    end else begin : g_hi
      assign lane_res[g*LANE_W +: LANE_W] = simd_i ? y : '0;
    end
  end

  // en[k]: stage k may capture this cycle (empty, or its content moves on).
  always_comb begin
    en = '0;
    en[STAGES-1] = ~v_q[STAGES-1] | ready_i;
    for (int unsigned i = STAGES - 1; i > 0; i--) begin
      en[i-1] = ~v_q[i-1] | en[i];
    end
  end

  assign ready_o = en[0];
  assign accept  = valid_i & en[0] & ~flush_i;

  always_comb begin
    v_d = v_q;
    if (en[0]) v_d[0] = accept;
    for (int unsigned i = 1; i < STAGES; i++) begin
      if (en[i]) v_d[i] = v_q[i-1];
    end
    if (flush_i) v_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v_q <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        res_q[i] <= '0;
        id_q[i]  <= '0;
      end
    end else begin
      v_q <= v_d;
      if (accept) begin
        res_q[0] <= lane_res;
        id_q[0]  <= trans_id_i;
      end
      for (int unsigned i = 1; i < STAGES; i++) begin
        if (en[i] && v_q[i-1]) begin
          res_q[i] <= res_q[i-1];
          id_q[i]  <= id_q[i-1];
        end
      end
    end
  end

  assign valid_o    = v_q[STAGES-1];
  assign result_o   = res_q[STAGES-1];
  assign trans_id_o = id_q[STAGES-1];
  assign busy_o     = |v_q;

endmodule

// File: tb/tb_sm3_perm_pipe.sv
// Scoreboard bench for sm3_perm_pipe: directed spec vectors plus randomized traffic vs. a behavioural model.
module tb_sm3_perm_pipe;

  localparam int XLEN   = 64;
  localparam int IDB    = 3;
  localparam int STAGES = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid_i, ready_o, simd_i, flush_i, valid_o, ready_i, busy_o;
  logic [IDB-1:0]  trans_id_i, trans_id_o;
  logic [1:0]      op_i;
  logic [XLEN-1:0] operand_i, result_o;

  sm3_perm_pipe #(.XLEN(XLEN), .TRANS_ID_BITS(IDB), .STAGES(STAGES)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
    .trans_id_i(trans_id_i), .op_i(op_i), .simd_i(simd_i), .operand_i(operand_i),
    .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .trans_id_o(trans_id_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [XLEN-1:0] res; logic [IDB-1:0] id; } exp_t;
  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;
  logic [XLEN-1:0] pend_res;
  logic [IDB-1:0]  pend_id;
  logic            rand_ready = 1'b0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: rotation via a doubled word, lanes assembled by mode.
  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x};
    return d[63-n -: 32];
  endfunction

  function automatic logic [31:0] fn(input logic [1:0] op, input logic [31:0] x);
    case (op)
      2'd0: return x ^ rl(x, 9) ^ rl(x, 17);
      2'd1: return x ^ rl(x, 15) ^ rl(x, 23);
`ifdef SM3_PERM_SM4_LINEAR_EN
      2'd2: return x ^ rl(x, 2) ^ rl(x, 10) ^ rl(x, 18) ^ rl(x, 24);
      2'd3: return x ^ rl(x, 13) ^ rl(x, 23);
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] model(input logic [1:0] op, input logic simd, input logic [XLEN-1:0] x);
    logic [31:0] hi;
    hi = simd ? fn(op, x[63:32]) : 32'h0;
    return {hi, fn(op, x[31:0])};
  endfunction

  // Monitor / scoreboard: drain output first, then flush, then capture accepted input.
  logic            stalled = 1'b0;
  logic [XLEN-1:0] st_res;
  logic [IDB-1:0]  st_id;
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      stalled = 1'b0;
    end else begin
      if (valid_o) begin
        if (stalled) begin
          check("stall_result_stable", result_o, st_res);
          check("stall_id_stable", {61'b0, trans_id_o}, {61'b0, st_id});
        end
        if (ready_i) begin
          stalled = 1'b0;
          if (q.size() == 0) begin
            check("unexpected_valid_o", {63'b0, valid_o}, 64'd0);
          end else begin
            exp_t e;
            e = q.pop_front();
            check("result", result_o, e.res);
            check("trans_id", {61'b0, trans_id_o}, {61'b0, e.id});
          end
        end else begin
          stalled = 1'b1;
          st_res  = result_o;
          st_id   = trans_id_o;
        end
      end else begin
        if (stalled) check("stall_valid_held", {63'b0, valid_o}, 64'd1);
        stalled = 1'b0;
      end
      if (flush_i) begin
        q.delete();
        stalled = 1'b0;
      end else if (valid_i && ready_o) begin
        q.push_back('{res: pend_res, id: pend_id});
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic set_req(input logic [1:0] op, input logic simd, input logic [XLEN-1:0] x,
                         input logic [IDB-1:0] id, input logic [XLEN-1:0] exp);
    op_i = op; simd_i = simd; operand_i = x; trans_id_i = id; valid_i = 1'b1;
    pend_res = exp; pend_id = id;
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [1:0] op, input logic simd, input logic [XLEN-1:0] x,
                      input logic [IDB-1:0] id, input logic [XLEN-1:0] exp);
    bit ok;
    set_req(op, simd, x, id, exp);
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (ready_o) begin ok = 1'b1; break; end
    end
    if (!ok) check("accept_timeout", {63'b0, ready_o}, 64'd1);
    @(posedge clk);
    #1 valid_i = 1'b0;
  endtask

  task automatic send_rand(input logic [IDB-1:0] id);
    logic [1:0]      op;
    logic            simd;
    logic [XLEN-1:0] x;
    op   = 2'($urandom_range(0, 3));
    simd = 1'($urandom_range(0, 1));
    x    = {$urandom, $urandom};
    send(op, simd, x, id, model(op, simd, x));
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1; simd_i = 1'b0;
    op_i = '0; operand_i = '0; trans_id_i = '0; pend_res = '0; pend_id = '0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check("rst_valid_o", {63'b0, valid_o}, 64'd0);
    check("rst_result_o", result_o, 64'd0);
    check("rst_trans_id_o", {61'b0, trans_id_o}, 64'd0);
    check("rst_busy_o", {63'b0, busy_o}, 64'd0);
    check("rst_ready_o", {63'b0, ready_o}, 64'd1);
    @(posedge clk); #1;

    // Latency: valid_o appears exactly STAGES cycles after accept.
    send(2'd0, 1'b0, 64'h1, 3'd5, 64'h0000_0000_0002_0201);
    for (int i = 0; i < STAGES - 1; i++) begin
      @(negedge clk);
      check("latency_early", {63'b0, valid_o}, 64'd0);
    end
    @(negedge clk);
    check("latency_valid", {63'b0, valid_o}, 64'd1);
    @(posedge clk); #1;

    send(2'd1, 1'b0, 64'h1, 3'd1, 64'h0000_0000_0080_8001);
    send(2'd0, 1'b0, 64'h8000_0000, 3'd2, 64'h0000_0000_8001_0100);
    send(2'd0, 1'b1, 64'h8000_0000_0000_0001, 3'd3, 64'h8001_0100_0002_0201);
    send(2'd0, 1'b0, 64'h8000_0000_0000_0001, 3'd4, 64'h0000_0000_0002_0201);
`ifdef SM3_PERM_SM4_LINEAR_EN
    send(2'd2, 1'b0, 64'h1, 3'd6, 64'h0000_0000_0104_0405);
    send(2'd3, 1'b0, 64'h1, 3'd7, 64'h0000_0000_0080_2001);
`else
    send(2'd2, 1'b1, 64'h1234_5678_0000_0001, 3'd6, 64'h0);
    send(2'd3, 1'b1, 64'hFFFF_FFFF_0000_0001, 3'd7, 64'h0);
`endif
    repeat (STAGES + 2) @(posedge clk);
    #1;

    // Backpressure: fill with ready_i low, expect ready_o to drop, then release.
    ready_i = 1'b0;
    for (int i = 0; i < STAGES; i++) send_rand(IDB'(i));
    set_req(2'd1, 1'b1, 64'hDEAD_BEEF_0BAD_F00D, IDB'(STAGES), model(2'd1, 1'b1, 64'hDEAD_BEEF_0BAD_F00D));
    repeat (3) begin
      @(negedge clk);
      check("bp_ready_low", {63'b0, ready_o}, 64'd0);
      check("bp_valid_held", {63'b0, valid_o}, 64'd1);
    end
    @(posedge clk); #1 ready_i = 1'b1;
    send(2'd1, 1'b1, 64'hDEAD_BEEF_0BAD_F00D, IDB'(STAGES), model(2'd1, 1'b1, 64'hDEAD_BEEF_0BAD_F00D));
    for (int i = STAGES + 1; i < 4; i++) send_rand(IDB'(i));
    repeat (STAGES + 2) @(posedge clk);
    #1;

    // Flush with entries in flight and a same-cycle request.
    send_rand(3'd1);
    send_rand(3'd2);
    set_req(2'd0, 1'b0, 64'h55, 3'd3, 64'h0);
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0; valid_i = 1'b0;
    check("flush_busy", {63'b0, busy_o}, 64'd0);
    check("flush_valid", {63'b0, valid_o}, 64'd0);
    repeat (4) begin
      @(negedge clk);
      check("post_flush_valid", {63'b0, valid_o}, 64'd0);
    end
    @(posedge clk); #1;

    // Randomized traffic with random consumer stalls and occasional flushes.
    rand_ready = 1'b1;
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 24) == 0) begin
        set_req(2'd0, 1'b1, {$urandom, $urandom}, 3'd0, 64'h0);
        valid_i = 1'($urandom_range(0, 1));
        flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0; valid_i = 1'b0;
      end else begin
        send_rand(IDB'(t));
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      end
    end
    rand_ready = 1'b0;
    @(posedge clk); #2 ready_i = 1'b1;

    // Asynchronous reset in the middle of traffic.
    send_rand(3'd1);
    send_rand(3'd2);
    #2 rst = 1'b1;
    #1;
    check("arst_valid_o", {63'b0, valid_o}, 64'd0);
    check("arst_busy_o", {63'b0, busy_o}, 64'd0);
    check("arst_result_o", result_o, 64'd0);
    #5 rst = 1'b0;
    @(posedge clk); #1;
    send(2'd1, 1'b1, 64'h0000_0001_0000_0001, 3'd4, 64'h0080_8001_0080_8001);

    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy_o) break;
    end
    check("drain_queue_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
